bp_cce_mshr_bank: RTL and testbench

BP_CCE_MSHR_BANK -- requirements
Module: bp_cce_mshr_bank

---
 rtl/bp_cce_mshr_bank.sv | 166 ++++++++++++++++
 tb/tb_bp_cce_mshr_bank.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_mshr_bank.sv
// Bank of miss-status holding registers plus the CCE general-purpose registers.
// Slots are handed out lowest-free-first; a slot freed this cycle can be re-granted at once.
module bp_cce_mshr_bank #(
   parameter int num_mshr_p        = 4,
   parameter int num_gpr_p         = 8,
   parameter int gpr_width_p       = 64,
   parameter int paddr_width_p     = 40,
   parameter int lce_id_width_p    = 4,
   parameter int lce_assoc_width_p = 3,
   parameter int num_flags_p       = 16,
   localparam int mshr_id_w_lp     = $clog2(num_mshr_p),
   localparam int gpr_id_w_lp      = $clog2(num_gpr_p),
   localparam int mshr_w_lp        = 2*lce_id_width_p + 2*paddr_width_p
                                     + 3*lce_assoc_width_p + 6 + num_flags_p
) (
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic                             alloc_v_i,
   output logic                             alloc_ready_o,
   output logic [mshr_id_w_lp-1:0]          alloc_id_o,
   input  logic                             free_v_i,
   input  logic [mshr_id_w_lp-1:0]          free_id_i,
   input  logic [mshr_id_w_lp-1:0]          sel_id_i,
   input  logic                             stall_i,
   input  logic [gpr_width_p-1:0]           src_i,
   input  logic [8:0]                       field_w_v_i,
   input  logic [num_flags_p-1:0]           flag_w_mask_i,
   input  logic [num_flags_p-1:0]           flag_data_i,
   input  logic                             coh_state_w_v_i,
   input  logic [num_gpr_p-1:0]             gpr_w_mask_i,
   input  logic [gpr_width_p-1:0]           gpr_data_i,
   input  logic                             dir_addr_v_i,
   input  logic [gpr_id_w_lp-1:0]           dir_addr_gpr_i,
   input  logic [paddr_width_p-1:0]         dir_addr_i,
   input  logic                             dir_lru_v_i,
   input  logic [paddr_width_p-1:0]         dir_lru_addr_i,
   input  logic [2:0]                       dir_lru_coh_state_i,
   output logic [mshr_w_lp-1:0]             mshr_o,
   output logic [num_mshr_p-1:0]            mshr_valid_o,
   output logic [mshr_id_w_lp:0]            occupancy_o,
   output logic [num_gpr_p*gpr_width_p-1:0] gpr_o,
   output logic [2:0]                       coh_state_o
);

   localparam logic [2:0] coh_i_lp = 3'd0;

   // Field order (MSB first) is the layout seen on mshr_o.
   typedef struct packed {
      logic [lce_id_width_p-1:0]    lce_id;
      logic [paddr_width_p-1:0]     paddr;
      logic [lce_assoc_width_p-1:0] way_id;
      logic [lce_assoc_width_p-1:0] lru_way_id;
      logic [paddr_width_p-1:0]     lru_paddr;
      logic [2:0]                   lru_coh_state;
      logic [lce_id_width_p-1:0]    owner_lce_id;
      logic [lce_assoc_width_p-1:0] owner_way_id;
      logic [2:0]                   next_coh_state;
      logic [num_flags_p-1:0]       flags;
   } mshr_s;

   mshr_s                   r_mshr [num_mshr_p];
   logic [num_mshr_p-1:0]   r_valid;
   logic [mshr_id_w_lp:0]   r_occ;
   logic [2:0]              r_coh;
   logic [gpr_width_p-1:0]  r_gpr [num_gpr_p];

   logic                    w_any_free;
   logic                    w_free_ok;
   logic                    w_alloc_fire;
   logic [mshr_id_w_lp-1:0] w_low_free;
   logic                    w_sel_ok;
   logic                    w_inst_wr;
   logic                    w_lru_wr;
   logic [num_mshr_p-1:0]   w_valid_nxt;
   logic [mshr_id_w_lp:0]   w_occ_nxt;
   logic [gpr_width_p-1:0]  w_dir_ext;

   always_comb begin
      w_low_free = '0;
      for (int i = num_mshr_p-1; i >= 0; i--) begin
         if (!r_valid[i]) w_low_free = mshr_id_w_lp'(i);
      end
   end

   assign w_any_free    = ~&r_valid;
   assign w_free_ok     = free_v_i & r_valid[free_id_i];
   assign alloc_ready_o = reset_i | w_any_free | w_free_ok;
   assign alloc_id_o    = reset_i ? '0 : (w_any_free ? w_low_free : free_id_i);
   assign w_alloc_fire  = alloc_v_i & alloc_ready_o;

   // A slot being freed this cycle discards any write aimed at it.
   assign w_sel_ok  = r_valid[sel_id_i] & ~(w_free_ok & (free_id_i == sel_id_i));
   assign w_inst_wr = w_sel_ok & ~stall_i;
   assign w_lru_wr  = w_sel_ok & dir_lru_v_i;

   always_comb begin
      w_valid_nxt = r_valid;
      if (w_free_ok)    w_valid_nxt[free_id_i]  = 1'b0;
      if (w_alloc_fire) w_valid_nxt[alloc_id_o] = 1'b1;
   end

   always_comb begin
      w_occ_nxt = r_occ;
      if (w_alloc_fire && !w_free_ok)      w_occ_nxt = r_occ + 1'b1;
      else if (!w_alloc_fire && w_free_ok) w_occ_nxt = r_occ - 1'b1;
   end

   always_comb begin
      w_dir_ext                    = '0;
      w_dir_ext[paddr_width_p-1:0] = dir_addr_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_valid <= '0;
         r_occ   <= '0;
         r_coh   <= coh_i_lp;
         for (int i = 0; i < num_mshr_p; i++) r_mshr[i] <= '0;
         for (int g = 0; g < num_gpr_p; g++)  r_gpr[g]  <= '0;
      end else begin
         r_valid <= w_valid_nxt;
         r_occ   <= w_occ_nxt;
         if (coh_state_w_v_i && !stall_i) r_coh <= src_i[2:0];
         for (int i = 0; i < num_mshr_p; i++) begin
            if (w_alloc_fire && (alloc_id_o == mshr_id_w_lp'(i))) begin
               r_mshr[i]                <= '0;
               r_mshr[i].next_coh_state <= r_coh;
            end else if (sel_id_i == mshr_id_w_lp'(i)) begin
               if (w_inst_wr) begin
                  if (field_w_v_i[0]) r_mshr[i].lce_id         <= src_i[lce_id_width_p-1:0];
                  if (field_w_v_i[1]) r_mshr[i].paddr          <= src_i[paddr_width_p-1:0];
                  if (field_w_v_i[2]) r_mshr[i].way_id         <= src_i[lce_assoc_width_p-1:0];
                  if (field_w_v_i[3]) r_mshr[i].lru_way_id     <= src_i[lce_assoc_width_p-1:0];
                  if (field_w_v_i[4]) r_mshr[i].lru_paddr      <= src_i[paddr_width_p-1:0];
                  if (field_w_v_i[5]) r_mshr[i].lru_coh_state  <= src_i[2:0];
                  if (field_w_v_i[6]) r_mshr[i].owner_lce_id   <= src_i[lce_id_width_p-1:0];
                  if (field_w_v_i[7]) r_mshr[i].owner_way_id   <= src_i[lce_assoc_width_p-1:0];
                  if (field_w_v_i[8]) r_mshr[i].next_coh_state <= src_i[2:0];
                  r_mshr[i].flags <= (r_mshr[i].flags & ~flag_w_mask_i)
                                   | (flag_data_i & flag_w_mask_i);
               end
               // Directory LRU update is not stallable and wins over instruction writes.
               if (w_lru_wr) begin
                  r_mshr[i].lru_paddr     <= dir_lru_addr_i;
                  r_mshr[i].lru_coh_state <= dir_lru_coh_state_i;
               end
            end
         end
         for (int g = 0; g < num_gpr_p; g++) begin
            if (dir_addr_v_i && (dir_addr_gpr_i == gpr_id_w_lp'(g))) r_gpr[g] <= w_dir_ext;
            else if (gpr_w_mask_i[g] && !stall_i)                    r_gpr[g] <= gpr_data_i;
         end
      end
   end

   always_comb begin
      gpr_o = '0;
      for (int g = 0; g < num_gpr_p; g++) gpr_o[g*gpr_width_p +: gpr_width_p] = r_gpr[g];
   end

   assign mshr_o       = r_mshr[sel_id_i];
   assign mshr_valid_o = r_valid;
   assign occupancy_o  = r_occ;
   assign coh_state_o  = r_coh;

endmodule

// File: tb/tb_bp_cce_mshr_bank.sv
// Self-checking bench for bp_cce_mshr_bank: directed scenarios plus random traffic
// compared against a slot/GPR array model.
module tb_bp_cce_mshr_bank;
   localparam int N = 4, G = 8, W = 64, PA = 40, LI = 4, LA = 3, NF = 16;

   typedef struct packed {
      logic [LI-1:0] lce_id;
      logic [PA-1:0] paddr;
      logic [LA-1:0] way_id;
      logic [LA-1:0] lru_way_id;
      logic [PA-1:0] lru_paddr;
      logic [2:0]    lru_coh;
      logic [LI-1:0] owner_lce;
      logic [LA-1:0] owner_way;
      logic [2:0]    next_coh;
      logic [NF-1:0] flags;
   } slot_t;

   logic clk = 1'b0;
   logic reset_i, alloc_v_i, free_v_i, stall_i, coh_state_w_v_i, dir_addr_v_i, dir_lru_v_i;
   logic [1:0] free_id_i, sel_id_i;
   logic [W-1:0] src_i, gpr_data_i;
   logic [8:0] field_w_v_i;
   logic [NF-1:0] flag_w_mask_i, flag_data_i;
   logic [G-1:0] gpr_w_mask_i;
   logic [2:0] dir_addr_gpr_i, dir_lru_coh_state_i;
   logic [PA-1:0] dir_addr_i, dir_lru_addr_i;

   logic alloc_ready_o;
   logic [1:0] alloc_id_o;
   logic [$bits(slot_t)-1:0] mshr_o;
   logic [N-1:0] mshr_valid_o;
   logic [2:0] occupancy_o;
   logic [G*W-1:0] gpr_o;
   logic [2:0] coh_state_o;

   always #5 clk = ~clk;

   bp_cce_mshr_bank dut (
      .clk_i(clk), .reset_i(reset_i),
      .alloc_v_i(alloc_v_i), .alloc_ready_o(alloc_ready_o), .alloc_id_o(alloc_id_o),
      .free_v_i(free_v_i), .free_id_i(free_id_i),
      .sel_id_i(sel_id_i), .stall_i(stall_i), .src_i(src_i), .field_w_v_i(field_w_v_i),
      .flag_w_mask_i(flag_w_mask_i), .flag_data_i(flag_data_i), .coh_state_w_v_i(coh_state_w_v_i),
      .gpr_w_mask_i(gpr_w_mask_i), .gpr_data_i(gpr_data_i),
      .dir_addr_v_i(dir_addr_v_i), .dir_addr_gpr_i(dir_addr_gpr_i), .dir_addr_i(dir_addr_i),
      .dir_lru_v_i(dir_lru_v_i), .dir_lru_addr_i(dir_lru_addr_i),
      .dir_lru_coh_state_i(dir_lru_coh_state_i),
      .mshr_o(mshr_o), .mshr_valid_o(mshr_valid_o), .occupancy_o(occupancy_o),
      .gpr_o(gpr_o), .coh_state_o(coh_state_o)
   );

   bit           m_valid [N];
   slot_t        m_slot  [N];
   logic [W-1:0] m_gpr   [G];
   logic [2:0]   m_coh;
   int           m_occ;
   int           n_pass = 0;
   int           n_total = 0;

   function automatic bit exp_ready();
      if (reset_i) return 1'b1;
      for (int i = 0; i < N; i++) if (!m_valid[i]) return 1'b1;
      return free_v_i && m_valid[free_id_i];
   endfunction

   function automatic logic [1:0] exp_id();
      if (reset_i) return 2'd0;
      for (int i = 0; i < N; i++) if (!m_valid[i]) return 2'(i);
      return free_id_i;
   endfunction

   function automatic logic [N-1:0] exp_valid();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_valid[i];
      return v;
   endfunction

   function automatic logic [G*W-1:0] exp_gpr();
      logic [G*W-1:0] v;
      for (int g = 0; g < G; g++) v[g*W +: W] = m_gpr[g];
      return v;
   endfunction

   task automatic clear_inputs();
      alloc_v_i = 0; free_v_i = 0; free_id_i = 0; sel_id_i = 0; stall_i = 0;
      src_i = '0; field_w_v_i = '0; flag_w_mask_i = '0; flag_data_i = '0;
      coh_state_w_v_i = 0; gpr_w_mask_i = '0; gpr_data_i = '0;
      dir_addr_v_i = 0; dir_addr_gpr_i = '0; dir_addr_i = '0;
      dir_lru_v_i = 0; dir_lru_addr_i = '0; dir_lru_coh_state_i = '0;
   endtask

   // Advance the model by one cycle from the current inputs, then clock the DUT.
   task automatic tick();
      bit free_ok, fire;
      logic [1:0] aid;
      logic [2:0] old_coh;
      slot_t s;
      if (reset_i) begin
         for (int i = 0; i < N; i++) begin m_valid[i] = 0; m_slot[i] = '0; end
         for (int g = 0; g < G; g++) m_gpr[g] = '0;
         m_coh = 3'd0; m_occ = 0;
      end else begin
         free_ok = free_v_i && m_valid[free_id_i];
         fire    = alloc_v_i && exp_ready();
         aid     = exp_id();
         old_coh = m_coh;
         if (m_valid[sel_id_i] && !(free_ok && free_id_i == sel_id_i)) begin
            s = m_slot[sel_id_i];
            if (!stall_i) begin
               if (field_w_v_i[0]) s.lce_id     = src_i[LI-1:0];
               if (field_w_v_i[1]) s.paddr      = src_i[PA-1:0];
               if (field_w_v_i[2]) s.way_id     = src_i[LA-1:0];
               if (field_w_v_i[3]) s.lru_way_id = src_i[LA-1:0];
               if (field_w_v_i[4]) s.lru_paddr  = src_i[PA-1:0];
               if (field_w_v_i[5]) s.lru_coh    = src_i[2:0];
               if (field_w_v_i[6]) s.owner_lce  = src_i[LI-1:0];
               if (field_w_v_i[7]) s.owner_way  = src_i[LA-1:0];
               if (field_w_v_i[8]) s.next_coh   = src_i[2:0];
               for (int f = 0; f < NF; f++) if (flag_w_mask_i[f]) s.flags[f] = flag_data_i[f];
            end
            if (dir_lru_v_i) begin s.lru_paddr = dir_lru_addr_i; s.lru_coh = dir_lru_coh_state_i; end
            m_slot[sel_id_i] = s;
         end
         for (int g = 0; g < G; g++) begin
            if (!stall_i && gpr_w_mask_i[g]) m_gpr[g] = gpr_data_i;
            if (dir_addr_v_i && dir_addr_gpr_i == 3'(g)) m_gpr[g] = {{(W-PA){1'b0}}, dir_addr_i};
         end
         if (coh_state_w_v_i && !stall_i) m_coh = src_i[2:0];
         if (free_ok) begin m_valid[free_id_i] = 0; m_occ--; end
         if (fire) begin
            m_valid[aid] = 1; m_slot[aid] = '0; m_slot[aid].next_coh = old_coh; m_occ++;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      clear_inputs(); reset_i = 1; alloc_v_i = 1; free_v_i = 1; #1;
      n_total++;
      if (alloc_ready_o !== 1'b1) $display("FAIL reset_ready got=%b want=1", alloc_ready_o); else n_pass++;
      n_total++;
      if (alloc_id_o !== 2'd0) $display("FAIL reset_id got=%0d want=0", alloc_id_o); else n_pass++;
      tick(); tick();
      n_total++;
      if (mshr_valid_o !== 4'b0) $display("FAIL reset_valid got=%b want=0", mshr_valid_o); else n_pass++;
      n_total++;
      if (occupancy_o !== 3'd0) $display("FAIL reset_occ got=%0d want=0", occupancy_o); else n_pass++;
      n_total++;
      if (coh_state_o !== 3'd0) $display("FAIL reset_coh got=%0d want=0", coh_state_o); else n_pass++;
      n_total++;
      if (gpr_o !== '0 || mshr_o !== '0) $display("FAIL reset_regs gpr=%h mshr=%h want=0", gpr_o, mshr_o); else n_pass++;
      reset_i = 0; clear_inputs();
   endtask

   task automatic test_back_to_back();
      clear_inputs(); alloc_v_i = 1;
      for (int i = 0; i < N; i++) begin
         #1; n_total++;
         if (alloc_id_o !== 2'(i)) $display("FAIL b2b_id got=%0d want=%0d", alloc_id_o, i); else n_pass++;
         tick();
      end
      clear_inputs(); #1;
      n_total++;
      if (occupancy_o !== 3'd4) $display("FAIL b2b_occ got=%0d want=4", occupancy_o); else n_pass++;
      n_total++;
      if (alloc_ready_o !== 1'b0) $display("FAIL b2b_ready got=%b want=0", alloc_ready_o); else n_pass++;
      n_total++;
      if (mshr_valid_o !== 4'hf) $display("FAIL b2b_valid got=%b want=1111", mshr_valid_o); else n_pass++;
   endtask

   task automatic test_full_reuse();
      clear_inputs(); sel_id_i = 2; field_w_v_i = 9'h1ff;
      src_i = {$urandom, $urandom} | 64'h1; flag_w_mask_i = '1; flag_data_i = 16'hbeef;
      tick(); clear_inputs(); sel_id_i = 2; #1;
      n_total++;
      if (mshr_o !== m_slot[2] || mshr_o === '0) $display("FAIL reuse_prewrite got=%h want=%h", mshr_o, m_slot[2]); else n_pass++;
      free_v_i = 1; free_id_i = 2; alloc_v_i = 1; #1;
      n_total++;
      if (alloc_ready_o !== 1'b1) $display("FAIL reuse_ready got=%b want=1", alloc_ready_o); else n_pass++;
      n_total++;
      if (alloc_id_o !== 2'd2) $display("FAIL reuse_id got=%0d want=2", alloc_id_o); else n_pass++;
      tick(); clear_inputs(); sel_id_i = 2; #1;
      n_total++;
      if (mshr_o !== '0) $display("FAIL reuse_zeroed got=%h want=0", mshr_o); else n_pass++;
      n_total++;
      if (occupancy_o !== 3'd4) $display("FAIL reuse_occ got=%0d want=4", occupancy_o); else n_pass++;
   endtask

   task automatic test_stall_field();
      slot_t got;
      clear_inputs(); sel_id_i = 1; field_w_v_i = 9'b000000010;
      src_i = 64'h0000_0012_3456_7890; stall_i = 1;
      tick(); got = slot_t'(mshr_o);
      n_total++;
      if (got.paddr !== 40'h0) $display("FAIL stall_paddr got=%h want=0", got.paddr); else n_pass++;
      stall_i = 0;
      tick(); got = slot_t'(mshr_o);
      n_total++;
      if (got.paddr !== 40'h12_3456_7890) $display("FAIL unstall_paddr got=%h want=1234567890", got.paddr); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_dir_addr();
      clear_inputs(); stall_i = 1; dir_addr_v_i = 1; dir_addr_gpr_i = 3; dir_addr_i = 40'hABC;
      gpr_w_mask_i = 8'h08; gpr_data_i = 64'h5;
      tick();
      n_total++;
      if (gpr_o[3*W +: W] !== 64'hABC) $display("FAIL dir_gpr3 got=%h want=abc", gpr_o[3*W +: W]); else n_pass++;
      clear_inputs(); gpr_w_mask_i = 8'h0c; gpr_data_i = 64'h777;
      tick();
      n_total++;
      if (gpr_o[3*W +: W] !== 64'h777 || gpr_o[2*W +: W] !== 64'h777 || gpr_o[4*W +: W] !== 64'h0)
         $display("FAIL gpr_mask got3=%h got2=%h got4=%h want=777/777/0",
                  gpr_o[3*W +: W], gpr_o[2*W +: W], gpr_o[4*W +: W]);
      else n_pass++;
      clear_inputs();
   endtask

   task automatic test_coh_and_bad_free();
      slot_t got;
      clear_inputs(); coh_state_w_v_i = 1; src_i = 64'h3;
      tick();
      n_total++;
      if (coh_state_o !== 3'd3) $display("FAIL coh_write got=%0d want=3", coh_state_o); else n_pass++;
      clear_inputs(); free_v_i = 1; free_id_i = 0;
      tick();
      clear_inputs(); alloc_v_i = 1; #1;
      n_total++;
      if (alloc_id_o !== 2'd0) $display("FAIL coh_alloc_id got=%0d want=0", alloc_id_o); else n_pass++;
      tick(); clear_inputs(); sel_id_i = 0; #1; got = slot_t'(mshr_o);
      n_total++;
      if (got.next_coh !== 3'd3) $display("FAIL coh_next got=%0d want=3", got.next_coh); else n_pass++;
      free_v_i = 1; free_id_i = 1;
      tick(); tick();
      n_total++;
      if (occupancy_o !== 3'd3) $display("FAIL bad_free_occ got=%0d want=3", occupancy_o); else n_pass++;
      n_total++;
      if (mshr_valid_o !== 4'b1101) $display("FAIL bad_free_valid got=%b want=1101", mshr_valid_o); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_random();
      logic [63:0] r;
      for (int it = 0; it < 400; it++) begin
         reset_i         = ($urandom_range(0, 59) == 0);
         alloc_v_i       = $urandom_range(0, 1);
         free_v_i        = ($urandom_range(0, 9) < 4);
         free_id_i       = 2'($urandom);
         sel_id_i        = 2'($urandom);
         stall_i         = ($urandom_range(0, 9) < 3);
         src_i           = {$urandom, $urandom};
         field_w_v_i     = 9'($urandom);
         flag_w_mask_i   = 16'($urandom);
         flag_data_i     = 16'($urandom);
         coh_state_w_v_i = ($urandom_range(0, 9) == 0);
         gpr_w_mask_i    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h0;
         gpr_data_i      = {$urandom, $urandom};
         dir_addr_v_i    = ($urandom_range(0, 4) == 0);
         dir_addr_gpr_i  = 3'($urandom);
         r = {$urandom, $urandom}; dir_addr_i = r[PA-1:0];
         dir_lru_v_i     = ($urandom_range(0, 4) == 0);
         r = {$urandom, $urandom}; dir_lru_addr_i = r[PA-1:0];
         dir_lru_coh_state_i = 3'($urandom);
         #1;
         n_total++;
         if (alloc_ready_o !== exp_ready()) $display("FAIL rnd_ready it=%0d got=%b want=%b", it, alloc_ready_o, exp_ready()); else n_pass++;
         n_total++;
         if (alloc_id_o !== exp_id()) $display("FAIL rnd_id it=%0d got=%0d want=%0d", it, alloc_id_o, exp_id()); else n_pass++;
         tick();
         n_total++;
         if (mshr_o !== m_slot[sel_id_i]) $display("FAIL rnd_mshr it=%0d got=%h want=%h", it, mshr_o, m_slot[sel_id_i]); else n_pass++;
         n_total++;
         if (mshr_valid_o !== exp_valid()) $display("FAIL rnd_valid it=%0d got=%b want=%b", it, mshr_valid_o, exp_valid()); else n_pass++;
         n_total++;
         if (occupancy_o !== 3'(m_occ)) $display("FAIL rnd_occ it=%0d got=%0d want=%0d", it, occupancy_o, m_occ); else n_pass++;
         n_total++;
         if (coh_state_o !== m_coh) $display("FAIL rnd_coh it=%0d got=%0d want=%0d", it, coh_state_o, m_coh); else n_pass++;
         n_total++;
         if (gpr_o !== exp_gpr()) $display("FAIL rnd_gpr it=%0d got=%h want=%h", it, gpr_o, exp_gpr()); else n_pass++;
      end
      reset_i = 0; clear_inputs();
   endtask

   task automatic test_reset_priority();
      clear_inputs(); reset_i = 1; tick(); reset_i = 0;
      alloc_v_i = 1; tick(); tick(); tick();
      n_total++;
      if (occupancy_o !== 3'd3) $display("FAIL rstpri_pre_occ got=%0d want=3", occupancy_o); else n_pass++;
      reset_i = 1; alloc_v_i = 1;
      tick();
      n_total++;
      if (occupancy_o !== 3'd0) $display("FAIL rstpri_occ got=%0d want=0", occupancy_o); else n_pass++;
      n_total++;
      if (mshr_valid_o !== 4'b0) $display("FAIL rstpri_valid got=%b want=0", mshr_valid_o); else n_pass++;
      reset_i = 0; clear_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs(); reset_i = 1;
      @(posedge clk); #1;
      test_reset();
      test_back_to_back();
      test_full_reuse();
      test_stall_field();
      test_dir_addr();
      test_coh_and_bad_free();
      test_random();
      test_reset_priority();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
